// File: rtl/stopwatch_counter.sv
// stopwatch_counter: mm:ss BCD stopwatch counting rising edges of derivClock in the baseClock domain; STOPWATCH_LAP_EN adds a lap display hold
module stopwatch_counter #(
    parameter logic [6:0] MINUTE_MAX = 7'd59
) (
    input  logic       baseClock,
    input  logic       reset,
    input  logic       derivClock,
    input  logic       startStop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
    output logic       lapHeld,
`endif
    output logic [3:0] secOnes,
    output logic [3:0] secTens,
    output logic [3:0] minOnes,
    output logic [3:0] minTens,
    output logic       running,
    output logic       secTick,
    output logic       wrapPulse
);
    localparam logic [3:0] MIN_TENS = 4'(MINUTE_MAX / 7'd10);
    localparam logic [3:0] MIN_ONES = 4'(MINUTE_MAX % 7'd10);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

    state_t     r_state, w_next_state;
    logic       r_deriv_prev, r_sec_tick, r_wrap;
    logic       w_tick, w_count, w_at_limit;
    logic [3:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
    logic [3:0] w_sec_ones_nx, w_sec_tens_nx, w_min_ones_nx, w_min_tens_nx;

    assign w_tick     = derivClock & ~r_deriv_prev;
    assign w_count    = (r_state == RUNNING) & w_tick & ~clear;
    assign w_at_limit = ({r_min_tens, r_min_ones} == {MIN_TENS, MIN_ONES}) &&
                        (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);
    assign running    = (r_state == RUNNING);
    assign secTick    = r_sec_tick;
    assign wrapPulse  = r_wrap;

    // Next state: clear wins, otherwise startStop toggles between running and paused
    always_comb begin
        w_next_state = r_state;
        if (clear)
            w_next_state = IDLE;
        else if (startStop)
            w_next_state = (r_state == RUNNING) ? PAUSED : RUNNING;
    end

    // BCD increment cascade with wrap to 00:00 at MINUTE_MAX:59
    always_comb begin
        w_sec_ones_nx = r_sec_ones;
        w_sec_tens_nx = r_sec_tens;
        w_min_ones_nx = r_min_ones;
        w_min_tens_nx = r_min_tens;
        if (w_at_limit) begin
            w_sec_ones_nx = 4'd0;
            w_sec_tens_nx = 4'd0;
            w_min_ones_nx = 4'd0;
            w_min_tens_nx = 4'd0;
        end else begin
            w_sec_ones_nx = (r_sec_ones == 4'd9) ? 4'd0 : r_sec_ones + 4'd1;
            if (r_sec_ones == 4'd9) begin
                w_sec_tens_nx = (r_sec_tens == 4'd5) ? 4'd0 : r_sec_tens + 4'd1;
                if (r_sec_tens == 4'd5) begin
                    w_min_ones_nx = (r_min_ones == 4'd9) ? 4'd0 : r_min_ones + 4'd1;
                    if (r_min_ones == 4'd9)
                        w_min_tens_nx = (r_min_tens == 4'd9) ? 4'd0 : r_min_tens + 4'd1;
                end
            end
        end
    end

    // State, edge-detect history, count digits and registered pulses
    always_ff @(posedge baseClock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_deriv_prev <= 1'b0;
            r_sec_tick   <= 1'b0;
            r_wrap       <= 1'b0;
            r_sec_ones   <= 4'd0;
            r_sec_tens   <= 4'd0;
            r_min_ones   <= 4'd0;
            r_min_tens   <= 4'd0;
        end else begin
            r_state      <= w_next_state;
            r_deriv_prev <= derivClock;
            r_sec_tick   <= w_count;
            r_wrap       <= w_count & w_at_limit;
            if (clear) begin
                r_sec_ones <= 4'd0;
                r_sec_tens <= 4'd0;
                r_min_ones <= 4'd0;
                r_min_tens <= 4'd0;
            end else if (w_count) begin
                r_sec_ones <= w_sec_ones_nx;
                r_sec_tens <= w_sec_tens_nx;
                r_min_ones <= w_min_ones_nx;
                r_min_tens <= w_min_tens_nx;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        r_lap_held;
    logic [15:0] r_lap_digits;

    // Lap toggles the display hold while running, snapshotting the live count
    always_ff @(posedge baseClock) begin
        if (reset || clear) begin
            r_lap_held   <= 1'b0;
            r_lap_digits <= 16'd0;
        end else if (lap && r_state == RUNNING) begin
            r_lap_held   <= ~r_lap_held;
            r_lap_digits <= {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
        end
    end

    assign lapHeld = r_lap_held;
    assign {minTens, minOnes, secTens, secOnes} = r_lap_held ? r_lap_digits :
                                                  {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
`else
    assign {minTens, minOnes, secTens, secOnes} = {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
`endif
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: scoreboard bench for two stopwatch_counter instances (MINUTE_MAX 59 and 2)
module tb_stopwatch_counter;
    logic clk = 1'b0;
    logic rst = 1'b1, d = 1'b0, ss = 1'b0, cl = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
    logic       run0, tk0, wp0, run1, tk1, wp1, lh0, lh1;
`ifdef STOPWATCH_LAP_EN
    logic lap = 1'b0;
`endif

    stopwatch_counter u0 (
        .baseClock(clk), .reset(rst), .derivClock(d), .startStop(ss), .clear(cl),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .lapHeld(lh0),
`endif
        .secOnes(so0), .secTens(st0), .minOnes(mo0), .minTens(mt0),
        .running(run0), .secTick(tk0), .wrapPulse(wp0)
    );

    stopwatch_counter #(.MINUTE_MAX(7'd2)) u1 (
        .baseClock(clk), .reset(rst), .derivClock(d), .startStop(ss), .clear(cl),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .lapHeld(lh1),
`endif
        .secOnes(so1), .secTens(st1), .minOnes(mo1), .minTens(mt1),
        .running(run1), .secTick(tk1), .wrapPulse(wp1)
    );

`ifndef STOPWATCH_LAP_EN
    assign lh0 = 1'b0;
    assign lh1 = 1'b0;
`endif

    int          tests = 0, fails = 0;
    string       phase = "reset";
    logic [19:0] q[$];
    int          m_secs[2], m_cap[2];
    logic        m_held[2];
    int          m_st = 0;
    logic        m_prev = 1'b0;

    function automatic logic [19:0] exp_vec(int s, logic h, logic r, logic t, logic w);
        exp_vec = {h, r, t, w, 4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic step(input logic i_d, input logic i_ss, input logic i_cl, input logic i_rst, input logic i_lap);
        logic        tick, en, wr;
        int          ns, lim;
        logic [19:0] e0, e1;
        @(negedge clk);
        d = i_d; ss = i_ss; cl = i_cl; rst = i_rst;
`ifdef STOPWATCH_LAP_EN
        lap = i_lap;
`endif
        tick = i_d & ~m_prev;
        ns = (i_rst || i_cl) ? 0 : (i_ss ? ((m_st == 1) ? 2 : 1) : m_st);
        for (int k = 0; k < 2; k++) begin
            lim = (k == 0) ? 3600 : 180;
            en = 1'b0;
            wr = 1'b0;
            if (i_rst || i_cl) begin
                m_secs[k] = 0;
                m_held[k] = 1'b0;
            end else begin
`ifdef STOPWATCH_LAP_EN
                if (i_lap && m_st == 1) begin
                    if (!m_held[k]) m_cap[k] = m_secs[k];
                    m_held[k] = ~m_held[k];
                end
`endif
                en = (m_st == 1) && tick;
                wr = en && (m_secs[k] == lim - 1);
                if (en) m_secs[k] = (m_secs[k] + 1) % lim;
            end
            q.push_back(exp_vec(m_held[k] ? m_cap[k] : m_secs[k], m_held[k], ns == 1, en, wr));
        end
        m_st = ns;
        m_prev = i_rst ? 1'b0 : i_d;
        @(posedge clk);
        #1;
        e0 = q.pop_front();
        e1 = q.pop_front();
        tests++;
        assert ({lh0, run0, tk0, wp0, mt0, mo0, st0, so0} === e0) else begin
            fails++;
            $error("FAIL %s max59 got=%h expected=%h", phase, {lh0, run0, tk0, wp0, mt0, mo0, st0, so0}, e0);
        end
        tests++;
        assert ({lh1, run1, tk1, wp1, mt1, mo1, st1, so1} === e1) else begin
            fails++;
            $error("FAIL %s max2 got=%h expected=%h", phase, {lh1, run1, tk1, wp1, mt1, mo1, st1, so1}, e1);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        m_secs = '{0, 0};
        m_cap  = '{0, 0};
        m_held = '{1'b0, 1'b0};
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        phase = "start3";
        step(0, 1, 0, 0, 0);
        ticks(3);
        phase = "cascade_wrap";
        ticks(3597);
        phase = "pause";
        ticks(5);
        step(0, 1, 0, 0, 0);
        ticks(4);
        step(0, 1, 0, 0, 0);
        ticks(1);
        phase = "clear_start";
        ticks(1);
        step(0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        ticks(2);
        phase = "level_high";
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        phase = "resume_high";
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        ticks(1);
        phase = "stop_with_tick";
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(1);
        phase = "clear_tick";
        step(1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(2);
        phase = "reset_mid";
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(10);
`ifdef STOPWATCH_LAP_EN
        phase = "lap";
        step(0, 0, 0, 0, 1);
        ticks(5);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        phase = "lap_paused";
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        ticks(2);
        step(0, 1, 0, 0, 0);
        phase = "lap_clear";
        step(0, 0, 0, 0, 1);
        ticks(2);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Consumes the divided clock from the clock-divider stage and keeps an mm:ss BCD stopwatch count.
- Runs entirely in the baseClock domain. derivClock is sampled as a data input and is never used as a clock.
- One second elapses on each rising edge of derivClock.
- Start/stop and clear controls come from debounced single-cycle pulses. The BCD digits feed the display decoder downstream.

Parameters:
- MINUTE_MAX, 7'd59: highest minute value before wrap. Legal range 0..99. Split at elaboration into tens digit = MINUTE_MAX/10 and ones digit = MINUTE_MAX%10.

Ports:
- baseClock, input, 1: system clock. The only clock of the block.
- reset, input, 1: synchronous, active-high reset, sampled on posedge baseClock.
- derivClock, input, 1: divided clock from the divider stage. Registered in the baseClock domain, so no synchroniser is required.
- startStop, input, 1: one-cycle pulse that toggles run/pause.
- clear, input, 1: one-cycle pulse that returns to IDLE with the count zeroed.
- secOnes, output, 4: seconds ones digit, BCD 0..9.
- secTens, output, 4: seconds tens digit, BCD 0..5.
- minOnes, output, 4: minutes ones digit, BCD 0..9.
- minTens, output, 4: minutes tens digit, BCD 0..9.
- running, output, 1: high while the state is RUNNING.
- secTick, output, 1: one-cycle pulse, coincident with each count increment.
- wrapPulse, output, 1: one-cycle pulse when the count rolls from MINUTE_MAX:59 to 00:00.

Behaviour:
- **Reset:** all digits 0, running=0, secTick=0, wrapPulse=0, state IDLE, derivPrev=0.
- **Edge detect:**
  - derivPrev <= derivClock every cycle.
  - tick = derivClock & ~derivPrev, combinational.
  - A falling edge or a level held high produces no tick.
- **State machine (IDLE, RUNNING, PAUSED):**
  - IDLE: startStop moves to RUNNING.
  - RUNNING: startStop moves to PAUSED.
  - PAUSED: startStop moves to RUNNING.
  - clear in any state moves to IDLE and zeroes all digits.
- **Priority:** reset > clear > startStop/tick.
- **Counting:**
  - A count happens only when the current (registered) state is RUNNING and tick=1.
  - A tick in the same cycle as startStop out of IDLE or PAUSED is NOT counted.
  - A tick in the same cycle as startStop out of RUNNING IS counted, and the state becomes PAUSED.
- **Latency:** digits and secTick update on the first posedge after the cycle in which derivClock is first seen high. That is one baseClock cycle after derivClock rises.
- **BCD cascade:**
  - secOnes 9 -> 0 and carries.
  - secTens 5 -> 0 and carries.
  - minOnes 9 -> 0 and carries, except at the limit.
  - The count is at the limit when minTens:minOnes equals MINUTE_MAX and secTens:secOnes = 59. The next tick sets all digits to 0 and pulses wrapPulse for one cycle.
  - Digits never leave their legal BCD range.
- **Pulse outputs:** secTick and wrapPulse are registered. Each stays high for exactly one cycle, and they are 0 in any cycle where clear or reset is asserted.
- **PAUSED:** digits are held. Ticks are ignored, but derivPrev keeps tracking derivClock, so resuming while derivClock is high does not produce a spurious tick.
- **Reset mid-count:** reset takes effect on the next posedge regardless of state or pending tick.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- **Defined:** adds input lap (1-bit pulse) and output lapHeld (1).
  - lap in RUNNING toggles lapHeld.
  - While lapHeld=1, the digit outputs are frozen at the value captured on the lap cycle. The internal count keeps running, and secTick/wrapPulse still fire.
  - Toggling lap again releases the outputs to the live count on the next cycle.
  - clear or reset sets lapHeld=0.
  - lap is ignored in IDLE and PAUSED.
- **Undefined:** no lap port and no lapHeld port. The digits always show the live count.

Test Plan:
1. reset, startStop, then 3 derivClock rising edges -> digits 00:03, 3 secTick pulses, each one cycle after its rising edge.
2. RUNNING from 00:59, 1 rising edge -> 01:00. From 09:59, 1 edge -> 10:00.
3. MINUTE_MAX=59, count 59:59, 1 edge -> 00:00, wrapPulse=1 for exactly 1 cycle. With MINUTE_MAX=2, 02:59 + 1 edge -> 00:00.
4. RUNNING at 00:05, startStop, then 4 edges -> stays 00:05 and running=0. startStop, then 1 edge -> 00:06.
5. startStop and clear in the same cycle while at 00:07 -> IDLE, 00:00, running=0. Then startStop together with a tick in the same cycle -> RUNNING, count still 00:00.
6. With STOPWATCH_LAP_EN defined: at 00:10 assert lap, then 5 edges -> outputs show 00:10, lapHeld=1. Assert lap again -> outputs show 00:15.
